// File: rtl/tdc_pkg.sv
// Shared TDC types/constants; macro TDC_BUBBLE_FILTER_EN selects the bubble-filter pipeline depth.
// Event record is sized from the package defaults, so non-default NTAPS/COARSE_W also need these updated.
package tdc_pkg;

  function automatic int fineW(input int nTaps);
    return $clog2(nTaps + 1);
  endfunction

  localparam int TDC_NTAPS    = 64;
  localparam int TDC_COARSE_W = 16;
  localparam int TDC_FINE_W   = fineW(TDC_NTAPS);

  typedef struct packed {
    logic [TDC_FINE_W-1:0]   fine;
    logic [TDC_COARSE_W-1:0] coarse;
  } tdcEvent_t;

`ifdef TDC_BUBBLE_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

endpackage

// File: rtl/tdc_popcount.sv
// Two-level pipelined popcount of the tap vector with sideband valid/tag.
// Latency 2 clk, no backpressure: one vector accepted every clk.
module tdc_popcount import tdc_pkg::*; #(
  parameter int NTAPS = 64,
  parameter int GROUP = 8,
  parameter int TAG_W = 16,
  localparam int FINE_W = fineW(NTAPS)
) (
  input  logic              clk,
  input  logic              iRst,
  input  logic              iVld,
  input  logic [TAG_W-1:0]  iTag,
  input  logic [NTAPS-1:0]  iTaps,
  output logic              oVld,
  output logic [TAG_W-1:0]  oTag,
  output logic [FINE_W-1:0] oFine
);

  localparam int NGRP   = NTAPS / GROUP;
  localparam int PART_W = $clog2(GROUP + 1);

  logic [NGRP-1:0][PART_W-1:0] partNext, part;
  logic                        vld1;
  logic [TAG_W-1:0]            tag1;
  logic [FINE_W-1:0]           sumNext;

  always_comb begin
    partNext = '0;
    for (int g = 0; g < NGRP; g++)
      for (int b = 0; b < GROUP; b++)
        partNext[g] = partNext[g] + PART_W'(iTaps[g*GROUP + b]);
  end

  always_comb begin
    sumNext = '0;
    for (int g = 0; g < NGRP; g++)
      sumNext = sumNext + FINE_W'(part[g]);
  end

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      part  <= '0;
      vld1  <= 1'b0;
      tag1  <= '0;
      oVld  <= 1'b0;
      oTag  <= '0;
      oFine <= '0;
    end else begin
      part  <= partNext;
      vld1  <= iVld;
      tag1  <= iTag;
      oVld  <= vld1;
      oTag  <= tag1;
      oFine <= sumNext;
    end
  end

endmodule

// File: rtl/tdc_hit_encoder.sv
// TDC hit encoder: edge-detects hits, encodes fine (ones count) + coarse tag, queues in a FWFT FIFO.
// Latency iTaps->oValid 3 clk (4 with TDC_BUBBLE_FILTER_EN); on a full FIFO without pop the event is dropped and oOverflow set.
module tdc_hit_encoder import tdc_pkg::*; #(
  parameter int NTAPS      = TDC_NTAPS,
  parameter int GROUP      = 8,
  parameter int COARSE_W   = TDC_COARSE_W,
  parameter int FIFO_DEPTH = 4,
  localparam int FINE_W    = fineW(NTAPS)
) (
  input  logic                clk,
  input  logic                iRst,
  input  logic [NTAPS-1:0]    iTaps,
  input  logic                iReady,
  input  logic                iClrOvf,
  output logic                oValid,
  output logic [FINE_W-1:0]   oFine,
  output logic [COARSE_W-1:0] oCoarse,
  output logic                oOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [COARSE_W-1:0] coarseCnt, c0;
  logic [NTAPS-1:0]    t0;
  logic                p0, evt0;

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      coarseCnt <= '0;
      c0        <= '0;
      t0        <= '0;
      p0        <= 1'b0;
    end else begin
      coarseCnt <= coarseCnt + 1'b1;
      c0        <= coarseCnt;
      t0        <= iTaps;
      p0        <= t0[0];
    end
  end

  // Rising edge of the launch tap only, so a held hit yields one event.
  assign evt0 = t0[0] & ~p0;

  logic [NTAPS-1:0]    pcTaps;
  logic                pcVld;
  logic [COARSE_W-1:0] pcTag;

`ifdef TDC_BUBBLE_FILTER_EN
  logic [NTAPS+1:0] ext;
  logic [NTAPS-1:0] majNext, tf;
  logic             evtF;
  logic [COARSE_W-1:0] cF;

  // Padded so the launch side reads as 1 and the far end as 0.
  assign ext = {1'b0, t0, 1'b1};

  always_comb begin
    majNext = '0;
    for (int i = 0; i < NTAPS; i++)
      majNext[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
  end

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      tf   <= '0;
      evtF <= 1'b0;
      cF   <= '0;
    end else begin
      tf   <= majNext;
      evtF <= evt0;
      cF   <= c0;
    end
  end

  assign pcTaps = tf;
  assign pcVld  = evtF;
  assign pcTag  = cF;
`else
  assign pcTaps = t0;
  assign pcVld  = evt0;
  assign pcTag  = c0;
`endif

  logic              push;
  logic [FINE_W-1:0] pcFine;
  logic [COARSE_W-1:0] pushTag;

  tdc_popcount #(
    .NTAPS (NTAPS),
    .GROUP (GROUP),
    .TAG_W (COARSE_W)
  ) uPopcount (
    .clk   (clk),
    .iRst  (iRst),
    .iVld  (pcVld),
    .iTag  (pcTag),
    .iTaps (pcTaps),
    .oVld  (push),
    .oTag  (pushTag),
    .oFine (pcFine)
  );

  tdcEvent_t mem [FIFO_DEPTH];
  tdcEvent_t evtIn, head, lastEvt, outEvt;
  logic [AW:0] wrPtr, rdPtr;
  logic        empty, full, pop, accept, drop;

  assign evtIn  = {pcFine, pushTag};
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign pop    = ~empty & iReady;
  // When full, the slot being written is the one popped this cycle.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign head   = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (accept) mem[wrPtr[AW-1:0]] <= evtIn;
  end

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      lastEvt   <= '0;
      oOverflow <= 1'b0;
    end else begin
      if (accept) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr   <= rdPtr + 1'b1;
        lastEvt <= head;
      end
      if (drop)         oOverflow <= 1'b1;
      else if (iClrOvf) oOverflow <= 1'b0;
    end
  end

  // Empty FIFO presents the last popped event so outputs never glitch to stale slots.
  assign outEvt  = empty ? lastEvt : head;
  assign oValid  = ~empty;
  assign oFine   = outEvt.fine;
  assign oCoarse = outEvt.coarse;

endmodule

// File: doc/tdc_hit_encoder.md
Name: tdc_hit_encoder

Overview:
Downstream stage of the hit input flip-flop and its tapped carry delay chain. It takes the thermometer vector captured from the chain on every clk edge and detects each new hit. It encodes the hit position as a fine time (count of ones in the vector) and tags it with a free-running coarse counter value. Each event is queued in a small first-word-fall-through FIFO and handed to the readout logic through a valid/ready handshake.

Parameters:
NTAPS, 64, number of delay-chain taps in iTaps; multiple of GROUP
GROUP, 8, taps per first-level partial popcount
COARSE_W, 16, coarse counter width
FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock, same clock that clears the hit flip-flop
iRst  in  1  asynchronous reset, active-low
iTaps  in  NTAPS  chain tap samples; bit 0 is nearest the hit launch point
iReady  in  1  consumer accepts the head event when high with oValid
iClrOvf  in  1  synchronous clear of oOverflow
oValid  out  1  head event available
oFine  out  FINE_W  ones count of the event vector, 0..NTAPS; FINE_W = clog2(NTAPS+1)
oCoarse  out  COARSE_W  coarse count tagged to the event
oOverflow  out  1  sticky flag: at least one event was dropped

Behaviour:
- Reset (iRst low, async): all pipeline registers, coarse counter, FIFO pointers and overflow flag go to 0. oValid=0, oFine=0, oCoarse=0, oOverflow=0. Any events in flight are discarded.
- Coarse counter: increments every clk and wraps from 2^COARSE_W-1 to 0.
- S0 (edge k): register iTaps into t0. Register the prior t0[0] as p0. Capture the coarse count into c0.
- Detect: evt0 = t0[0] & ~p0. Consecutive samples with t0[0]=1 give one event only, so minimum dead time is one clk.
- S1 (edge k+1): one partial popcount per GROUP slice of t0. evt and coarse tag travel alongside.
- S2 (edge k+2): sum the partials into fine, FINE_W bits, with no saturation needed. All ones gives fine = NTAPS. All zeros with evt cannot occur, because evt requires t0[0]=1.
- S3 (edge k+3): when evt, write {fine, coarse} into the FIFO. oValid rises after edge k+3 if the FIFO was empty. Latency from iTaps to oValid is 3 clk.
- Handshake: pop on oValid & iReady. oFine/oCoarse stay stable while oValid=1 and iReady=0. When the FIFO is empty, oFine/oCoarse keep their last values.
- Full FIFO, push with pop in the same cycle: the push is accepted and occupancy is unchanged.
- Full FIFO, push without pop: the event is dropped and oOverflow=1 from the next edge.
- oOverflow clears on iClrOvf. If a drop and iClrOvf occur in the same cycle, set wins.
- Empty FIFO with a push: no bypass; oValid appears on the following edge as stated above.

Optional Feature:
Macro: TDC_BUBBLE_FILTER_EN.
- Defined: one extra register stage after S0. Each tap is replaced by the majority of (t[i-1], t[i], t[i+1]), with t[-1]=1 and t[NTAPS]=0. evt uses the raw t0[0]. Latency becomes 4 clk, and the coarse tag is still the S0 value.
- Undefined: raw t0 goes straight to popcount, with latency 3.

Decomposition:
- Package tdc_pkg holds:
  - the clog2-based FINE_W function
  - the event record type {fine, coarse}
  - the LAT constant, 3 or 4 according to the macro
- Sub-module tdc_popcount holds the pipelined two-level popcount (S1/S2). It has parameters NTAPS and GROUP and carries a sideband valid and tag.
- The FIFO stays inline.

Test Plan:
- Reset mid-stream: FIFO holds 2 events, drive iRst low -> oValid=0, oOverflow=0, coarse restarts at 0 after release.
- Single hit: iTaps = 0x0000_0000_0000_001F for one cycle at coarse 10, zeros otherwise, iReady=1 -> oValid one cycle after 3 clk, oFine=5, oCoarse=10.
- Held high: iTaps=all ones for 3 consecutive cycles -> exactly one event, oFine=64.
- Backpressure: iReady=0 with 5 hits spaced 2 clk apart -> 4 events held in order, oOverflow=1. iClrOvf then clears it, and draining gives 4 pops with the correct fine/coarse values.
- Full plus simultaneous pop: FIFO full, pop in the same cycle as an incoming event -> no drop, oOverflow stays 0.
- With TDC_BUBBLE_FILTER_EN: iTaps=0b1101_1111 (bubble at bit 5) -> oFine=8 after 4 clk. Without the macro the same input gives oFine=7 after 3 clk.
